// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - keypad scanner signal bundle (column sense in, row drive and key report out)
interface keypad_scanner_if;
  logic [3:0] cols;
  logic [3:0] row_drive;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  cols,
    output row_drive,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    output cols,
    input  row_drive,
    input  key_code,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner, one report per press
// Rows are driven one-hot in turn; columns are sampled at the end of each row dwell.
module keypad_scanner #(
  parameter int SETTLE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  keypad_scanner_if.master kp
);

  localparam int CW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic {ST_SCAN, ST_HELD} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt,   w_cnt_nxt;
  logic [3:0]    r_row,   w_row_nxt;
  logic [3:0]    r_code,  w_code_nxt;
  logic          r_valid, w_valid_nxt;
  logic          r_held,  w_held_nxt;

  logic [1:0]    w_row_idx;
  logic [1:0]    w_col_idx;
  logic [3:0]    w_row_rot;
  logic          w_any_col;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
      4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
      4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
      4'hC: k = 4'hE;  4'hD: k = 4'h0;  4'hE: k = 4'hF;  default: k = 4'hD;
    endcase
    return k;
  endfunction

  assign w_any_col = (kp.cols != 4'b0000);
  assign w_row_rot = {r_row[2:0], r_row[3]};

  always_comb begin
    w_row_idx = 2'd0;
    case (r_row)
      4'b0010: w_row_idx = 2'd1;
      4'b0100: w_row_idx = 2'd2;
      4'b1000: w_row_idx = 2'd3;
      default: w_row_idx = 2'd0;
    endcase
  end

  // Lowest-index column wins when several are active.
  always_comb begin
    w_col_idx = 2'd3;
    if (kp.cols[0])      w_col_idx = 2'd0;
    else if (kp.cols[1]) w_col_idx = 2'd1;
    else if (kp.cols[2]) w_col_idx = 2'd2;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_row_nxt   = r_row;
    w_code_nxt  = r_code;
    w_valid_nxt = 1'b0;
    w_held_nxt  = r_held;
    case (r_state)
      ST_SCAN: begin
        if (r_cnt == LAST) begin
          w_cnt_nxt = '0;
          if (w_any_col) begin
            w_code_nxt  = key_map(w_row_idx, w_col_idx);
            w_valid_nxt = 1'b1;
            w_held_nxt  = 1'b1;
            w_state_nxt = ST_HELD;
          end else begin
            w_row_nxt = w_row_rot;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_HELD: begin
        // A single idle column sample counts as release; debouncing happens upstream.
        if (!w_any_col) begin
          w_held_nxt  = 1'b0;
          w_state_nxt = ST_SCAN;
          w_row_nxt   = w_row_rot;
          w_cnt_nxt   = '0;
        end
      end
      default: w_state_nxt = ST_SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_SCAN;
      r_cnt   <= '0;
      r_row   <= 4'b0001;
      r_code  <= 4'h0;
      r_valid <= 1'b0;
      r_held  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_row   <= w_row_nxt;
      r_code  <= w_code_nxt;
      r_valid <= w_valid_nxt;
      r_held  <= w_held_nxt;
    end
  end

  assign kp.row_drive = r_row;
  assign kp.key_code  = r_code;
  assign kp.key_valid = r_valid;
  assign kp.key_held  = r_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - self-checking bench for keypad_scanner
// Vector table, directed corner sequences, then random key activity against a dwell-time model.
module tb_keypad_scanner;

  localparam int S = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  keypad_scanner_if kp ();

  keypad_scanner #(.SETTLE_CYCLES(S)) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kp)
  );

  typedef struct {
    logic [3:0] cols;
    logic [3:0] row;
    logic [3:0] code;
    logic       valid;
    logic       held;
  } vec_t;

  vec_t tbl[$];

  localparam logic [3:0] KEYMAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  int n_chk  = 0;
  int n_fail = 0;

  // Model: m_t counts scan cycles since row 0 began; row = m_t / S, sample when m_t % S == S-1.
  int         m_t;
  logic       m_held;
  logic       m_valid;
  logic [3:0] m_code;

  function automatic int m_row();
    return (m_t / S) % 4;
  endfunction

  function automatic void add(input logic [3:0] c, input logic [3:0] r, input logic [3:0] k,
                              input logic v, input logic h);
    vec_t e;
    e = '{c, r, k, v, h};
    tbl.push_back(e);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_held = 1'b0; m_valid = 1'b0; m_code = 4'h0;
  endtask

  task automatic model_step(input logic [3:0] c);
    int col;
    m_valid = 1'b0;
    if (!m_held) begin
      if ((m_t % S) == S - 1 && c != 4'b0) begin
        col = 0;
        while (!c[col]) col++;
        m_code  = KEYMAP[m_row() * 4 + col];
        m_valid = 1'b1;
        m_held  = 1'b1;
      end else begin
        m_t = (m_t + 1) % (4 * S);
      end
    end else if (c == 4'b0) begin
      m_held = 1'b0;
      m_t    = ((m_t / S + 1) % 4) * S;
    end
  endtask

  function automatic logic [3:0] cols_of(input logic [15:0] mask);
    return mask[m_row() * 4 +: 4];
  endfunction

  // Called just after a negedge; applies cols across the next posedge and checks against the model.
  task automatic step(input logic [3:0] c);
    kp.cols = c;
    model_step(c);
    @(posedge clk);
    #1;
    chk("row_drive", kp.row_drive, 4'b0001 << m_row());
    chk("key_code",  kp.key_code,  m_code);
    chk("key_valid", kp.key_valid, m_valid);
    chk("key_held",  kp.key_held,  m_held);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [3:0] c);
    reset   = 1'b1;
    kp.cols = c;
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_row",   kp.row_drive, 4'b0001);
    chk("rst_code",  kp.key_code,  4'h0);
    chk("rst_valid", kp.key_valid, 1'b0);
    chk("rst_held",  kp.key_held,  1'b0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  int         valid_cnt;
  int         guard;
  logic [15:0] mask;
  int         dur;

  initial begin
    reset   = 1'b1;
    kp.cols = 4'b0;

    // Edge k of the table is k cycles after the reset edge; rows dwell S=4 cycles each.
    for (int k = 1; k <= 3; k++)   add(4'h0, 4'b0001, 4'h0, 1'b0, 1'b0);
    for (int k = 4; k <= 7; k++)   add(4'h0, 4'b0010, 4'h0, 1'b0, 1'b0);
    for (int k = 8; k <= 11; k++)  add(4'h0, 4'b0100, 4'h0, 1'b0, 1'b0);
    for (int k = 12; k <= 15; k++) add(4'h0, 4'b1000, 4'h0, 1'b0, 1'b0);
    for (int k = 16; k <= 19; k++) add(4'h0, 4'b0001, 4'h0, 1'b0, 1'b0);
    for (int k = 20; k <= 23; k++) add(4'h0, 4'b0010, 4'h0, 1'b0, 1'b0);
    add(4'h0, 4'b0100, 4'h0, 1'b0, 1'b0);
    for (int k = 25; k <= 27; k++) add(4'b0010, 4'b0100, 4'h0, 1'b0, 1'b0);
    add(4'b0010, 4'b0100, 4'h8, 1'b1, 1'b1);
    add(4'b0010, 4'b0100, 4'h8, 1'b0, 1'b1);

    @(negedge clk);
    do_reset(4'b0);
    foreach (tbl[i]) begin
      step(tbl[i].cols);
      chk($sformatf("tbl%0d_row", i),   kp.row_drive, tbl[i].row);
      chk($sformatf("tbl%0d_code", i),  kp.key_code,  tbl[i].code);
      chk($sformatf("tbl%0d_valid", i), kp.key_valid, tbl[i].valid);
      chk($sformatf("tbl%0d_held", i),  kp.key_held,  tbl[i].held);
    end

    // Key 8 held for 200 cycles, then released.
    valid_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      step(4'b0010);
      if (kp.key_valid) valid_cnt++;
    end
    chk("hold_no_revalid", valid_cnt, 0);
    chk("hold_held", kp.key_held, 1'b1);
    chk("hold_row", kp.row_drive, 4'b0100);
    step(4'b0000);
    chk("rel_held", kp.key_held, 1'b0);
    chk("rel_row", kp.row_drive, 4'b1000);
    chk("rel_code", kp.key_code, 4'h8);

    // Two columns on row 3: column 1 wins, giving key 0.
    for (int i = 0; i < S; i++) step(4'b1010);
    chk("multi_code", kp.key_code, 4'h0);
    chk("multi_valid", kp.key_valid, 1'b1);
    step(4'b0000);
    chk("multi_rel_row", kp.row_drive, 4'b0001);

    // One-cycle glitch on row 0 away from the sample cycle.
    valid_cnt = 0;
    step(4'b0001);
    for (int i = 0; i < 2 * S; i++) begin
      step(4'b0000);
      if (kp.key_valid) valid_cnt++;
    end
    chk("glitch_no_valid", valid_cnt, 0);
    chk("glitch_row", kp.row_drive, 4'b0100);

    // Press key 5, then reset while it is held.
    mask  = 16'h0020;
    guard = 0;
    while (!kp.key_held && guard < 8 * S) begin
      step(cols_of(mask));
      guard++;
    end
    chk("k5_held", kp.key_held, 1'b1);
    chk("k5_code", kp.key_code, 4'h5);
    do_reset(4'b0010);
    for (int i = 0; i < S + 1; i++) step(4'b0000);
    chk("post_rst_row", kp.row_drive, 4'b0010);

    // Random keypad activity: key masks seen through the driven row, plus stray column glitches.
    do_reset(4'b0);
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 3))
        0:       mask = 16'h0;
        1, 2:    mask = 16'h1 << $urandom_range(0, 15);
        default: mask = 16'($urandom);
      endcase
      dur = $urandom_range(1, 3 * 4 * S);
      for (int i = 0; i < dur; i++) begin
        if (mask == 16'h0 && $urandom_range(0, 7) == 0) step(4'($urandom));
        else step(cols_of(mask));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
